// File: rtl/bin_to_ascii_dec.sv
// Sequential binary-to-ASCII-decimal converter for the OSD debug overlay.
// A shift-and-add-3 (double-dabble) core runs one input bit per cycle. The
// result is formatted into a fixed-width ASCII field, with optional blanking
// of leading zeros and saturation to all '9' on overflow.

// Per-digit BCD correction: a nibble of 5 or more gets +3 before the shift.
module bin_to_ascii_dec_add3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

module bin_to_ascii_dec #(
  parameter int          BIN_W    = 14,
  parameter int          DIGITS   = 4,
  parameter int          BLANK_LZ = 1,
  parameter logic [7:0]  PAD_CHAR = 8'h20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [8*DIGITS-1:0]   ascii_out,
  output logic                  ovf,
  output logic                  out_valid
);

  if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
    $error("bin_to_ascii_dec: BIN_W must be in 1..32");
  end
  if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
    $error("bin_to_ascii_dec: DIGITS must be in 1..10");
  end

  // 10^10-1 needs 34 bits, so the limit compare is carried at least that wide.
  localparam int CMP_W = (BIN_W > 34) ? BIN_W : 34;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [CMP_W-1:0] MAX_VAL = CMP_W'(pow10(DIGITS) - 64'd1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FORMAT = 2'd2;

  logic [1:0]               state;
  logic [CNT_W-1:0]         count;
  logic [BIN_W-1:0]         shift_r;
  logic [DIGITS-1:0][3:0]   bcd_r;
  logic [DIGITS-1:0][3:0]   bcd_adj;
  logic [DIGITS-1:0][3:0]   bcd_next;
  logic [4*DIGITS:0]        bcd_shifted;
  logic                     unused_bcd_msb;
  logic                     ovf_r;
  logic [CMP_W-1:0]         bin_ext;
  logic [8*DIGITS-1:0]      field;
  logic                     seen_nz;

  assign in_ready = (state == IDLE);
  assign bin_ext  = CMP_W'(bin_in);

  bin_to_ascii_dec_add3 u_add3 [DIGITS-1:0] (
    .nib (bcd_r),
    .adj (bcd_adj)
  );

  // The top BCD bit falls off the end; only an overflowing input can set it,
  // and that case is replaced by the saturated field anyway.
  assign bcd_shifted    = {bcd_adj, shift_r[BIN_W-1]};
  assign bcd_next       = bcd_shifted[4*DIGITS-1:0];
  assign unused_bcd_msb = bcd_shifted[4*DIGITS];

  // Build the ASCII field from the finished BCD, top digit down, blanking
  // until the first non-zero nibble; the units digit always prints.
  always_comb begin
    field   = '0;
    seen_nz = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      seen_nz = seen_nz | (bcd_r[k] != 4'd0) | (k == 0);
      if (ovf_r)
        field[8*k +: 8] = 8'h39;
      else if ((BLANK_LZ != 0) && !seen_nz)
        field[8*k +: 8] = PAD_CHAR;
      else
        field[8*k +: 8] = {4'h3, bcd_r[k]};
    end
  end

  // Control FSM and datapath: accept, shift BIN_W times, format, publish.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      shift_r   <= '0;
      bcd_r     <= '0;
      ovf_r     <= 1'b0;
      ascii_out <= {DIGITS{8'h30}};
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_r <= bin_in;
            bcd_r   <= '0;
            ovf_r   <= (bin_ext > MAX_VAL);
            count   <= CNT_W'(BIN_W);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_r   <= bcd_next;
          shift_r <= shift_r << 1;
          count   <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= FORMAT;
        end
        FORMAT: begin
          ascii_out <= field;
          ovf       <= ovf_r;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_ascii_dec.sv
// Scoreboard bench for bin_to_ascii_dec over several parameter sets.
// Stimulus pushes the expected field, ovf flag and output cycle per DUT.
// A negedge monitor pops and compares on every out_valid pulse.
module tb_bin_to_ascii_dec;

  typedef struct {
    logic [79:0] asc;
    logic        ovf;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  iv;
  logic [4:0]  rdy;
  logic [4:0]  ov;
  logic [4:0]  of;
  logic [13:0] b0, b1;
  logic [31:0] b2;
  logic [19:0] b3;
  logic [0:0]  b4;
  logic [31:0] a0, a1;
  logic [79:0] a2;
  logic [23:0] a3;
  logic [7:0]  a4;
  logic [79:0] act [5];

  exp_t sb [5][$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_ascii_dec u_d0 (.clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(rdy[0]),
    .bin_in(b0), .ascii_out(a0), .ovf(of[0]), .out_valid(ov[0]));
  bin_to_ascii_dec #(.BLANK_LZ(0)) u_d1 (.clk(clk), .reset_n(reset_n), .in_valid(iv[1]),
    .in_ready(rdy[1]), .bin_in(b1), .ascii_out(a1), .ovf(of[1]), .out_valid(ov[1]));
  bin_to_ascii_dec #(.BIN_W(32), .DIGITS(10)) u_d2 (.clk(clk), .reset_n(reset_n),
    .in_valid(iv[2]), .in_ready(rdy[2]), .bin_in(b2), .ascii_out(a2), .ovf(of[2]),
    .out_valid(ov[2]));
  bin_to_ascii_dec #(.BIN_W(20), .DIGITS(3)) u_d3 (.clk(clk), .reset_n(reset_n),
    .in_valid(iv[3]), .in_ready(rdy[3]), .bin_in(b3), .ascii_out(a3), .ovf(of[3]),
    .out_valid(ov[3]));
  bin_to_ascii_dec #(.BIN_W(1), .DIGITS(1)) u_d4 (.clk(clk), .reset_n(reset_n),
    .in_valid(iv[4]), .in_ready(rdy[4]), .bin_in(b4), .ascii_out(a4), .ovf(of[4]),
    .out_valid(ov[4]));

  assign act[0] = {48'h0, a0};
  assign act[1] = {48'h0, a1};
  assign act[2] = a2;
  assign act[3] = {56'h0, a3};
  assign act[4] = {72'h0, a4};

  function automatic int bw(input int d);
    case (d)
      0, 1:    return 14;
      2:       return 32;
      3:       return 20;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Call at a negedge. Holds in_valid until the DUT is ready, records the
  // expected result, and returns at the negedge after the acceptance edge.
  task automatic send(input int d, input logic [31:0] v, input logic [79:0] asc,
                      input logic o, input bit hold);
    int   n;
    exp_t e;
    iv[d] = 1'b1;
    case (d)
      0: b0 = v[13:0];
      1: b1 = v[13:0];
      2: b2 = v;
      3: b3 = v[19:0];
      default: b4 = v[0:0];
    endcase
    n = 0;
    while (!rdy[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) begin
      total++;
      bad++;
      $display("FAIL accept_timeout dut%0d: got no in_ready want in_ready within 200 cycles", d);
    end
    e.asc = asc;
    e.ovf = o;
    e.due = cyc + bw(d) + 2;
    sb[d].push_back(e);
    @(negedge clk);
    if (!hold) iv[d] = 1'b0;
  endtask

  // Monitor: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 5; d++) begin
      if (ov[d]) begin : mon
        exp_t e;
        if (sb[d].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out dut%0d: got pulse with %h want no pulse", d, act[d]);
        end else begin
          e = sb[d].pop_front();
          chk($sformatf("ascii_dut%0d", d), act[d], e.asc);
          chk($sformatf("ovf_dut%0d", d), {79'h0, of[d]}, {79'h0, e.ovf});
          chk($sformatf("cycle_dut%0d", d), 80'(cyc), 80'(e.due));
        end
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0;
    iv = '0;
    b0 = '0; b1 = '0; b2 = '0; b3 = '0; b4 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ascii_d0", act[0], 80'h30303030);
    chk("rst_ascii_d2", act[2], 80'h30303030303030303030);
    chk("rst_ovf_d0", {79'h0, of[0]}, 80'h0);
    chk("rst_outv", {75'h0, ov}, 80'h0);
    chk("rst_ready", {75'h0, rdy}, 80'h1f);
    reset_n = 1'b1;
    @(negedge clk);

    // Default parameter set: plain values, blanking, interior zeros, saturation.
    send(0, 1234,  80'h31323334, 1'b0, 1'b0);
    send(0, 0,     80'h20202030, 1'b0, 1'b0);
    send(0, 7,     80'h20202037, 1'b0, 1'b0);
    send(0, 1002,  80'h31303032, 1'b0, 1'b0);
    send(0, 9999,  80'h39393939, 1'b0, 1'b0);
    send(0, 10000, 80'h39393939, 1'b1, 1'b0);
    send(0, 16383, 80'h39393939, 1'b1, 1'b0);

    // Back-to-back with in_valid held: second taken on the first pulse cycle.
    send(0, 42, 80'h20203432, 1'b0, 1'b1);
    send(0, 7,  80'h20202037, 1'b0, 1'b0);

    // Input churn while busy must be ignored.
    send(0, 500, 80'h20353030, 1'b0, 1'b1);
    b0 = 14'd9;
    repeat (6) @(negedge clk);
    iv[0] = 1'b0;

    // Reset in the middle of SHIFT drops the conversion without a pulse.
    send(0, 4321, 80'h34333231, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    void'(sb[0].pop_back());
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_ready", {79'h0, rdy[0]}, 80'h1);
    chk("midrst_ascii", act[0], 80'h30303030);
    chk("midrst_ovf", {79'h0, of[0]}, 80'h0);
    chk("midrst_outv", {79'h0, ov[0]}, 80'h0);
    send(0, 321, 80'h20333231, 1'b0, 1'b0);

    // No blanking.
    send(1, 0,    80'h30303030, 1'b0, 1'b0);
    send(1, 7,    80'h30303037, 1'b0, 1'b0);
    send(1, 1002, 80'h31303032, 1'b0, 1'b0);

    // Full 32-bit, ten digits.
    send(2, 32'hFFFF_FFFF, 80'h34323934393637323935, 1'b0, 1'b0);
    send(2, 0,             80'h20202020202020202030, 1'b0, 1'b0);
    send(2, 1000000000,    80'h31303030303030303030, 1'b0, 1'b0);

    // Narrow field, wide input.
    send(3, 999,     80'h393939, 1'b0, 1'b0);
    send(3, 1000,    80'h393939, 1'b1, 1'b0);
    send(3, 5,       80'h202035, 1'b0, 1'b0);
    send(3, 1048575, 80'h393939, 1'b1, 1'b0);

    // Degenerate one-bit, one-digit build.
    send(4, 1, 80'h31, 1'b0, 1'b0);
    send(4, 0, 80'h30, 1'b0, 1'b0);

    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() + sb[4].size()) != 0
           && n < 500) begin
      @(negedge clk);
      n++;
    end
    for (int d = 0; d < 5; d++) begin
      if (sb[d].size() != 0) begin
        total++;
        bad++;
        $display("FAIL drain_dut%0d: got %0d pending results want 0", d, sb[d].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
